line_buffer_win: RTL and testbench
==================================

Name: line_buffer_win

Overview:
- Parametrised single-line pixel buffer for sliding-window kernels.
- Stores one image line of LINE_LEN pixels, written one pixel per cycle.
- Once the line is complete, emits a KERNEL_W-pixel horizontal window per read request, with a registered output and valid strobe.
- Sits between the pixel input stream and the KxK convolution/MAC stage. Several instances are stacked to form the row set.

Parameters:
- DATA_W, 8: pixel width in bits.
- LINE_LEN, 512: pixels per line. Any value >= KERNEL_W; power of two not required.
- KERNEL_W, 3: window width in pixels. Must be >= 1.
- PTR_W, $clog2(LINE_LEN): pointer/counter width. Derived; not to be overridden.

Ports:
- i_clk  in  1  sole clock; all logic on rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_data  in  DATA_W  write pixel.
- i_data_valid  in  1  write request.
- o_wr_ready  out  1  buffer accepts writes this cycle.
- i_rd_data  in  1  read request; advances the window by one pixel.
- o_line_rdy  out  1  line complete, reads allowed.
- o_data  out  KERNEL_W*DATA_W  window; tap0 at MSBs, tap KERNEL_W-1 at LSBs.
- o_data_valid  out  1  o_data updated this cycle.
- o_wr_err  out  1  sticky: write attempted while o_wr_ready=0.
- o_rd_err  out  1  sticky: read attempted while o_line_rdy=0.
- i_clr_err  in  1  synchronous clear of both sticky errors.

Behaviour:
- One clock (i_clk). Reset i_rst_n is asynchronous, active-low. Deassertion is expected to be synchronised upstream.
- Reset values:
  - state=FILL; wrPntr=0; rdPntr=0; rd_cnt=0.
  - o_data=0; o_data_valid=0; o_wr_err=0; o_rd_err=0.
  - o_wr_ready=1; o_line_rdy=0.
  - Pixel RAM is not reset.
- State machine (2 states):
  - FILL: o_wr_ready=1, o_line_rdy=0.
    - Write accepted when i_data_valid=1: mem[wrPntr]<=i_data, wrPntr++.
    - On the accept where wrPntr==LINE_LEN-1: wrPntr<=0, next state READ.
  - READ: o_wr_ready=0, o_line_rdy=1.
    - Read accepted when i_rd_data=1: rdPntr and rd_cnt increment.
    - On the accept where rd_cnt==LINE_LEN-1: rdPntr<=0, rd_cnt<=0, next state FILL. o_wr_ready is 1 the following cycle.
- Both state outputs are decoded directly from the state register (no extra latency).
- Window taps:
  - tap k address = (rdPntr+k) mod LINE_LEN, k=0..KERNEL_W-1.
  - Modulo is done by compare/subtract, not by bit truncation (LINE_LEN may be non-power-of-two).
- Read latency: 1 cycle.
  - An accepted read at cycle N registers the window for the pre-increment rdPntr into o_data.
  - o_data_valid=1 at cycle N+1 for exactly one cycle per accepted read.
  - o_data holds its value between reads.
- Errors:
  - i_data_valid in READ: data dropped, no pointer change, o_wr_err<=1.
  - i_rd_data in FILL: ignored, o_rd_err<=1, o_data_valid stays 0.
  - i_clr_err has priority over a same-cycle set.
- Boundary conditions:
  - Last write and a simultaneous i_rd_data: the read is rejected and flagged (state is still FILL).
  - Last read and a simultaneous i_data_valid: the write is rejected and flagged (state is still READ).
  - Reset mid-line: all progress lost, buffer returns to FILL with pointers at 0.

Optional Feature:
- Macro: LINE_BUFFER_WIN_EDGE_REPLICATE_EN.
- Defined: tap addresses clamp at the line end. Address = min(rdPntr+k, LINE_LEN-1), so right-edge windows replicate the last pixel.
- Undefined: taps wrap modulo LINE_LEN, as stated above.
- Pointer and counter behaviour is identical in both cases.

Decomposition:
- Shared package lb_pkg holds:
  - state enum type lb_state_t {LB_FILL, LB_READ};
  - function lb_wrap_add(ptr, k, len), used for both wrap and clamp address arithmetic;
  - default constants LB_DATA_W=8, LB_LINE_LEN=512, LB_KERNEL_W=3.
- One natural sub-module: lb_tap_mux. It is combinational: it takes rdPntr and the RAM and produces the concatenated KERNEL_W taps, including the wrap/clamp logic.
- The top level holds the state machine, pointers, error flags and the output register.

Test Plan:
- Bench uses LINE_LEN=8, KERNEL_W=3, DATA_W=8.
- Reset then idle: assert i_rst_n=0 for 3 cycles, release, idle 5 cycles. Expect o_wr_ready=1, o_line_rdy=0, o_data=0, o_data_valid=0, both error flags 0.
- Fill and first window: write 0x10..0x17 on 8 consecutive cycles. Expect o_line_rdy=1 the cycle after the 8th write. A single i_rd_data then gives o_data=0x101112 with o_data_valid=1 one cycle later.
- Wrap: continue reads back-to-back. The 7th read gives 0x161710 and the 8th gives 0x171011. The cycle after the 8th accepted read: o_wr_ready=1, o_line_rdy=0.
- Replicate (macro defined): same stimulus. The 7th read gives 0x161717 and the 8th gives 0x171717.
- Errors: i_rd_data in FILL sets o_rd_err=1 with no o_data_valid. An extra write in READ (value 0xAA) sets o_wr_err=1, and the next window shows no 0xAA. A same-cycle i_clr_err plus a new error leaves the flag at 0.
- Reset mid-operation: after 5 writes, pulse i_rst_n low for 1 cycle. Then write 0x20..0x27. The first window is 0x202122 and o_line_rdy rises only after the 8th new write.

Source files
------------

// File: rtl/lb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lb_pkg
// Brief    : Shared types, default constants and address helper for the
//            line_buffer_win single-line pixel buffer.
// Revision : 1.0 - initial release
// ============================================================================
package lb_pkg;

  // Default build constants; instances may override the matching parameters.
  localparam int LB_DATA_W   = 8;
  localparam int LB_LINE_LEN = 512;
  localparam int LB_KERNEL_W = 3;

  // Buffer phase: collecting a line, or serving windows from it.
  typedef enum logic [0:0] {
    LB_FILL = 1'b0,
    LB_READ = 1'b1
  } lb_state_t;

  // Pointer advance by k with wrap at len, done by compare/subtract so that
  // non-power-of-two line lengths work. Callers detect a wrap by the result
  // being smaller than ptr (valid because k < len), which the clamp mode uses.
  function automatic int unsigned lb_wrap_add(input int unsigned ptr,
                                              input int unsigned k,
                                              input int unsigned len);
    int unsigned sum;
    sum = ptr + k;
    if (sum >= len) begin
      sum = sum - len;
    end
    return sum;
  endfunction

endpackage : lb_pkg
`default_nettype wire

// File: rtl/lb_tap_mux.sv
`default_nettype none
// ============================================================================
// Module   : lb_tap_mux
// Brief    : Combinational window selector. Produces KERNEL_W taps starting
//            at rd_ptr_i; tap0 lands in the MSBs of taps_o.
//            LINE_BUFFER_WIN_EDGE_REPLICATE_EN defined: taps clamp to the last
//            pixel of the line. Undefined: taps wrap modulo LINE_LEN.
// Revision : 1.0 - initial release
// ============================================================================
module lb_tap_mux
  import lb_pkg::*;
#(
  parameter int DATA_W   = LB_DATA_W,
  parameter int LINE_LEN = LB_LINE_LEN,
  parameter int KERNEL_W = LB_KERNEL_W,
  parameter int PTR_W    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1
) (
  input  logic [PTR_W-1:0]                 rd_ptr_i,
  input  logic [LINE_LEN-1:0][DATA_W-1:0]  mem_i,
  output logic [KERNEL_W*DATA_W-1:0]       taps_o
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(LINE_LEN - 1);

  for (genvar k = 0; k < KERNEL_W; k++) begin : g_tap
    logic [31:0]      wrap_addr;
    logic [PTR_W-1:0] tap_addr;

    assign wrap_addr = lb_wrap_add(32'(rd_ptr_i), k, LINE_LEN);

`ifdef LINE_BUFFER_WIN_EDGE_REPLICATE_EN
    // A wrapped result means rd_ptr+k ran past the line end: hold the last pixel.
    assign tap_addr = (wrap_addr < 32'(rd_ptr_i)) ? LAST_IDX : PTR_W'(wrap_addr);
`else
    assign tap_addr = PTR_W'(wrap_addr);
`endif

    assign taps_o[(KERNEL_W-1-k)*DATA_W +: DATA_W] = mem_i[tap_addr];
  end

endmodule : lb_tap_mux
`default_nettype wire

// File: rtl/line_buffer_win.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer_win
// Brief    : Single-line pixel buffer for sliding-window kernels. Fills one
//            line of LINE_LEN pixels, then serves one KERNEL_W-wide window per
//            read request with a registered output and valid strobe.
//            Optional macro LINE_BUFFER_WIN_EDGE_REPLICATE_EN selects edge
//            replication instead of wrap for right-edge windows.
// Revision : 1.0 - initial release
// ============================================================================
module line_buffer_win
  import lb_pkg::*;
#(
  parameter int DATA_W   = LB_DATA_W,
  parameter int LINE_LEN = LB_LINE_LEN,
  parameter int KERNEL_W = LB_KERNEL_W,
  parameter int PTR_W    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [DATA_W-1:0]            i_data,
  input  logic                         i_data_valid,
  output logic                         o_wr_ready,
  input  logic                         i_rd_data,
  output logic                         o_line_rdy,
  output logic [KERNEL_W*DATA_W-1:0]   o_data,
  output logic                         o_data_valid,
  output logic                         o_wr_err,
  output logic                         o_rd_err,
  input  logic                         i_clr_err
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(LINE_LEN - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  lb_state_t                         state_q, state_d;
  logic [PTR_W-1:0]                  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]                  rd_cnt_q, rd_cnt_d;
  logic [LINE_LEN-1:0][DATA_W-1:0]   mem_q;
  logic [KERNEL_W*DATA_W-1:0]        taps;
  logic [KERNEL_W*DATA_W-1:0]        data_q;
  logic                              data_valid_q;
  logic                              wr_err_q;
  logic                              rd_err_q;
  logic                              wr_en;
  logic                              rd_en;
  logic                              wr_err_set;
  logic                              rd_err_set;

  // Handshake outputs come straight from the state register.
  assign o_wr_ready   = (state_q == LB_FILL);
  assign o_line_rdy   = (state_q == LB_READ);
  assign o_data       = data_q;
  assign o_data_valid = data_valid_q;
  assign o_wr_err     = wr_err_q;
  assign o_rd_err     = rd_err_q;

  // Next-state, pointer advance and request acceptance/rejection decode.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_cnt_d   = rd_cnt_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    wr_err_set = 1'b0;
    rd_err_set = 1'b0;
    case (state_q)
      LB_FILL: begin
        rd_err_set = i_rd_data;
        if (i_data_valid) begin
          wr_en = 1'b1;
          if (wr_ptr_q == LAST_IDX) begin
            wr_ptr_d = '0;
            state_d  = LB_READ;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
          end
        end
      end
      LB_READ: begin
        wr_err_set = i_data_valid;
        if (i_rd_data) begin
          rd_en = 1'b1;
          if (rd_cnt_q == LAST_IDX) begin
            rd_ptr_d = '0;
            rd_cnt_d = '0;
            state_d  = LB_FILL;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            rd_cnt_d = rd_cnt_q + PTR_ONE;
          end
        end
      end
      default: begin
        state_d = LB_FILL;
      end
    endcase
  end

  // State and pointer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= LB_FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Pixel storage; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  lb_tap_mux #(
    .DATA_W   (DATA_W),
    .LINE_LEN (LINE_LEN),
    .KERNEL_W (KERNEL_W),
    .PTR_W    (PTR_W)
  ) u_tap_mux (
    .rd_ptr_i (rd_ptr_q),
    .mem_i    (mem_q),
    .taps_o   (taps)
  );

  // Window output register: captures taps for the pre-increment pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= rd_en;
      if (rd_en) begin
        data_q <= taps;
      end
    end
  end

  // Sticky error flags; clear wins over a same-cycle set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else if (i_clr_err) begin
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if (wr_err_set) wr_err_q <= 1'b1;
      if (rd_err_set) rd_err_q <= 1'b1;
    end
  end

endmodule : line_buffer_win
`default_nettype wire

// File: tb/tb_line_buffer_win.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_buffer_win
// Brief    : Self-checking bench for line_buffer_win (LINE_LEN=8, KERNEL_W=3,
//            DATA_W=8). Honours LINE_BUFFER_WIN_EDGE_REPLICATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_buffer_win;

  localparam int DW  = 8;
  localparam int LEN = 8;
  localparam int KW  = 3;

  logic              clk;
  logic              rst_n;
  logic [DW-1:0]     data;
  logic              data_valid;
  logic              wr_ready;
  logic              rd_data;
  logic              line_rdy;
  logic [KW*DW-1:0]  win;
  logic              win_valid;
  logic              wr_err;
  logic              rd_err;
  logic              clr_err;

  line_buffer_win #(
    .DATA_W   (DW),
    .LINE_LEN (LEN),
    .KERNEL_W (KW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data       (data),
    .i_data_valid (data_valid),
    .o_wr_ready   (wr_ready),
    .i_rd_data    (rd_data),
    .o_line_rdy   (line_rdy),
    .o_data       (win),
    .o_data_valid (win_valid),
    .o_wr_err     (wr_err),
    .o_rd_err     (rd_err),
    .i_clr_err    (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference: a line is either being collected or being read.
  logic [DW-1:0]    m_mem [LEN];
  bit               m_ready;
  int               m_wc;
  int               m_rc;
  logic [KW*DW-1:0] m_data;
  bit               m_valid;
  bit               m_werr;
  bit               m_rerr;

  typedef struct {
    logic          dv;
    logic [DW-1:0] d;
    logic          rd;
    logic          exp_line_rdy;
    logic          exp_valid;
    logic [23:0]   exp_data;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [KW*DW-1:0] model_win(input int p);
    logic [KW*DW-1:0] w;
    int idx;
    w = '0;
    for (int k = 0; k < KW; k++) begin
`ifdef LINE_BUFFER_WIN_EDGE_REPLICATE_EN
      idx = (p + k > LEN - 1) ? LEN - 1 : p + k;
`else
      idx = (p + k) % LEN;
`endif
      w = (w << DW) | (KW*DW)'(m_mem[idx]);
    end
    return w;
  endfunction

  task automatic model_reset();
    m_ready = 0; m_wc = 0; m_rc = 0;
    m_data = '0; m_valid = 0; m_werr = 0; m_rerr = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wr_ready"}, 64'(wr_ready), 64'(!m_ready));
    chk({tag, ".line_rdy"}, 64'(line_rdy), 64'(m_ready));
    chk({tag, ".valid"},    64'(win_valid), 64'(m_valid));
    chk({tag, ".data"},     64'(win), 64'(m_data));
    chk({tag, ".wr_err"},   64'(wr_err), 64'(m_werr));
    chk({tag, ".rd_err"},   64'(rd_err), 64'(m_rerr));
  endtask

  // One clock: drive inputs, step the model, then compare after the edge.
  task automatic cycle(input logic dv, input logic [DW-1:0] d,
                       input logic rd, input logic clr, input string tag);
    data = d; data_valid = dv; rd_data = rd; clr_err = clr;
    m_valid = 0;
    if (!m_ready) begin
      if (rd) m_rerr = 1;
      if (dv) begin
        m_mem[m_wc] = d;
        m_wc++;
        if (m_wc == LEN) begin m_wc = 0; m_ready = 1; end
      end
    end else begin
      if (dv) m_werr = 1;
      if (rd) begin
        m_data  = model_win(m_rc);
        m_valid = 1;
        m_rc++;
        if (m_rc == LEN) begin m_rc = 0; m_ready = 0; end
      end
    end
    if (clr) begin m_werr = 0; m_rerr = 0; end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    data_valid = 0; rd_data = 0; clr_err = 0; data = '0;
    model_reset();
    #1;
    check_all("in_reset");
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; data = '0; data_valid = 0; rd_data = 0; clr_err = 0;
    for (int i = 0; i < LEN; i++) m_mem[i] = '0;
    model_reset();

    // Directed fill + full read pass with literal expected windows.
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{dv: 1'b1, d: 8'(8'h10 + i), rd: 1'b0,
                 exp_line_rdy: (i == 7), exp_valid: 1'b0, exp_data: 24'h0};
    end
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 24'h101112};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 24'h111213};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 24'h121314};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 24'h131415};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 24'h141516};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 24'h151617};
`ifdef LINE_BUFFER_WIN_EDGE_REPLICATE_EN
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 24'h161717};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 24'h171717};
`else
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 24'h161710};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 24'h171011};
`endif

    // Reset then idle.
    @(posedge clk); #1;
    do_reset(3);
    for (int i = 0; i < 5; i++) cycle(0, '0, 0, 0, "idle");

    // Table-driven fill and wrap/replicate read pass.
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].dv, tbl[i].d, tbl[i].rd, 1'b0, "tbl");
      chk($sformatf("tbl%0d.line_rdy", i), 64'(line_rdy), 64'(tbl[i].exp_line_rdy));
      chk($sformatf("tbl%0d.valid", i), 64'(win_valid), 64'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d.data", i), 64'(win), 64'(tbl[i].exp_data));
    end
    chk("post_pass.wr_ready", 64'(wr_ready), 64'd1);

    // Read in FILL: flagged, no strobe.
    cycle(0, '0, 1, 0, "rd_in_fill");
    chk("rd_in_fill.rd_err", 64'(rd_err), 64'd1);
    chk("rd_in_fill.valid", 64'(win_valid), 64'd0);
    cycle(0, '0, 0, 1, "clr");

    // Fill; last write collides with a read request.
    for (int i = 0; i < 7; i++) cycle(1, 8'(8'h30 + i), 0, 0, "fill2");
    cycle(1, 8'h37, 1, 0, "last_wr_rd");
    chk("last_wr_rd.rd_err", 64'(rd_err), 64'd1);
    chk("last_wr_rd.line_rdy", 64'(line_rdy), 64'd1);
    cycle(0, '0, 0, 1, "clr2");

    // Write in READ is dropped and flagged.
    cycle(1, 8'hAA, 0, 0, "wr_in_read");
    chk("wr_in_read.wr_err", 64'(wr_err), 64'd1);
    cycle(0, '0, 1, 0, "no_aa");
    chk("no_aa.data", 64'(win), 64'h303132);

    // Clear wins over a same-cycle new error.
    cycle(1, 8'h55, 0, 1, "clr_vs_set");
    chk("clr_vs_set.wr_err", 64'(wr_err), 64'd0);

    // Remaining reads; last read collides with a write.
    for (int i = 0; i < 6; i++) cycle(0, '0, 1, 0, "drain");
    cycle(1, 8'h66, 1, 0, "last_rd_wr");
    chk("last_rd_wr.wr_err", 64'(wr_err), 64'd1);
    chk("last_rd_wr.wr_ready", 64'(wr_ready), 64'd1);
    cycle(0, '0, 0, 1, "clr3");
    cycle(0, '0, 0, 0, "post_clr");
    chk("post_clr.wr_ready", 64'(wr_ready), 64'd1);

    // Reset mid-line loses all progress.
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h40 + i), 0, 0, "partial");
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 8'(8'h20 + i), 0, 0, "refill");
      chk($sformatf("refill%0d.line_rdy", i), 64'(line_rdy), 64'(i == 7));
    end
    cycle(0, '0, 1, 0, "refill_rd");
    chk("refill_rd.data", 64'(win), 64'h202122);
    chk("refill_rd.valid", 64'(win_valid), 64'd1);
    for (int i = 0; i < 7; i++) cycle(0, '0, 1, 0, "refill_drain");

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_line_buffer_win
`default_nettype wire
